// File: rtl/shift_ctrl.sv
// Serializes a command word into an external shift register and captures the word shifted back out.
// Optional pause input enabled by defining SHIFT_CTRL_PAUSE_EN.
module shift_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_si,
  input  logic             sr_so,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef SHIFT_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] left_w, right_w;
  logic             stall;

`ifdef SHIFT_CTRL_PAUSE_EN
  // pause is registered so that no input reaches an output combinationally.
  logic pause_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_q <= 1'b0;
    else     pause_q <= pause;
  end
  assign stall = pause_q;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    rx_d    = rx_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          rx_d  = dir_q ? {sr_so, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], sr_so};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      rx_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
    end
  end

  // The current serial bit sits at the MSB (left) or LSB (right) after shifting by the count.
  assign left_w  = data_q << cnt_q;
  assign right_w = data_q >> cnt_q;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sr_en     = (state_q == SHIFT) && !stall;
  assign sr_dir    = (state_q == SHIFT) && dir_q;
  assign sr_si     = (state_q == SHIFT) && (dir_q ? right_w[0] : left_w[WIDTH-1]);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rx_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: external shift register model, cycle-indexed reference model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_shift_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_dir = 1'b0;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_ready = 1'b0;
  logic         sr_so;
  logic         cmd_ready, sr_en, sr_dir, sr_si, rsp_valid, busy;
  logic [W-1:0] rsp_data;
`ifdef SHIFT_CTRL_PAUSE_EN
  logic         pause = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_data  (cmd_data),
    .sr_en     (sr_en),
    .sr_dir    (sr_dir),
    .sr_si     (sr_si),
    .sr_so     (sr_so),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef SHIFT_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External shift register driven by the controller.
  logic [W-1:0] ext = '0;
  logic [W-1:0] load_val = '0;
  logic         load_req = 1'b0;
  always @(posedge clk) begin
    if (load_req)   ext <= load_val;
    else if (sr_en) ext <= sr_dir ? {sr_si, ext[W-1:1]} : {ext[W-2:0], sr_si};
  end
  assign sr_so = sr_dir ? ext[0] : ext[W-1];

  // Reference model: a command accepted at the end of cycle A shifts during cycles A+1..A+W
  // and responds from cycle A+W+1 until the handshake.
  int           cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         m_busy = 1'b0;
  int           m_acc = 0;
  logic         m_dir = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_rsp = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1;
        m_acc  <= cyc;
        m_dir  <= cmd_dir;
        m_data <= cmd_data;
        m_rsp  <= ext;
      end
    end else if ((cyc - m_acc > W) && rsp_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int   k;
    logic shifting, in_resp, e_si;
    k        = cyc - m_acc;
    shifting = m_busy && (k >= 1) && (k <= W);
    in_resp  = m_busy && (k > W);
    e_si     = 1'b0;
    if (shifting) e_si = m_dir ? m_data[k-1] : m_data[W-k];
    check("sr_en", sr_en, shifting);
    check("sr_dir", sr_dir, shifting && m_dir);
    check("sr_si", sr_si, e_si);
    check("cmd_ready", cmd_ready, !m_busy);
    check("busy", busy, m_busy);
    check("rsp_valid", rsp_valid, in_resp);
    if (in_resp) check("rsp_data", rsp_data, m_rsp);
  end

  // Observation counters for the directed scenarios.
  int           en_total = 0;
  logic [W-1:0] seq = '0;
  int           acc_n = 0;
  int           acc_cyc [16];
  always @(negedge clk) begin
    if (sr_en) begin
      en_total <= en_total + 1;
      seq      <= {seq[W-2:0], sr_si};
    end
    if (cmd_ready && cmd_valid && !rst) begin
      acc_cyc[acc_n % 16] <= cyc;
      acc_n               <= acc_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [W-1:0] v);
    load_val = v;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    for (int i = 0; i < 40 && !rsp_valid; i++) tick();
    check({name, " rsp_valid within budget"}, rsp_valid, 1'b1);
  endtask

  task automatic run_cmd(input string name, input logic dir, input logic [W-1:0] data,
                         input logic [W-1:0] pre, input logic [W-1:0] exp_seq,
                         input logic [W-1:0] exp_rsp);
    int e0;
    preload(pre);
    e0        = en_total;
    rsp_ready = 1'b1;
    cmd_dir   = dir;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_resp(name);
    check({name, " sr_si sequence"}, seq, exp_seq);
    check({name, " sr_en cycles"}, en_total - e0, W);
    check({name, " rsp_data"}, rsp_data, exp_rsp);
    check({name, " register end"}, ext, data);
    tick();
    check({name, " idle after handshake"}, busy, 1'b0);
  endtask

  initial begin
    int a0, n;
    // Reset values while rst is held.
    #1 rst = 1'b1;
    #1;
    check("reset cmd_ready", cmd_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset sr_en", sr_en, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_data", rsp_data, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_cmd("left A5", 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C);
    run_cmd("right 01", 1'b1, 8'h01, 8'h80, 8'h80, 8'h80);
    run_cmd("right D4", 1'b1, 8'hD4, 8'h2B, 8'h2B, 8'h2B);

    // Response back-pressure with a competing command held valid.
    preload(8'h5A);
    rsp_ready = 1'b0;
    cmd_dir   = 1'b0;
    cmd_data  = 8'h0F;
    cmd_valid = 1'b1;
    tick();
    cmd_dir  = 1'b1;
    cmd_data = 8'hFF;
    a0       = acc_n;
    wait_resp("stall");
    for (int i = 0; i < 5; i++) begin
      check("stall rsp_valid", rsp_valid, 1'b1);
      check("stall rsp_data", rsp_data, 8'h5A);
      check("stall cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    check("stall no accept", acc_n, a0);
    rsp_ready = 1'b1;
    tick();
    tick();
    cmd_valid = 1'b0;
    check("stall next accepted", acc_n, a0 + 1);
    wait_resp("after stall");
    check("after stall rsp_data", rsp_data, 8'h0F);
    tick();

    // Reset during the third SHIFT cycle.
    preload(8'h77);
    cmd_dir   = 1'b0;
    cmd_data  = 8'hAA;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("pre-abort sr_en", sr_en, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort sr_en", sr_en, 1'b0);
    check("abort sr_dir", sr_dir, 1'b0);
    check("abort sr_si", sr_si, 1'b0);
    check("abort cmd_ready", cmd_ready, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort rsp_valid", rsp_valid, 1'b0);
    check("abort rsp_data", rsp_data, '0);
    #1 rst = 1'b0;
    run_cmd("post-reset C3", 1'b0, 8'hC3, 8'h5A, 8'hC3, 8'h5A);

    // Back-to-back commands.
    a0        = acc_n;
    rsp_ready = 1'b1;
    cmd_dir   = 1'b1;
    cmd_data  = 8'h96;
    cmd_valid = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("b2b drained", busy, 1'b0);
    n = acc_n - a0;
    check("b2b accept count", n, 4);
    for (int i = 1; i < n && i < 16; i++)
      check("b2b interval", acc_cyc[(a0 + i) % 16] - acc_cyc[(a0 + i - 1) % 16], 10);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
